axi_mem_subordinate: RTL

// AXI4 subordinate endpoint: responder side of the channels the crossbar routes to a subordinate port.

---
 rtl/axi_mem_subordinate.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_subordinate.sv
// AXI4 subordinate that turns FIXED/INCR bursts into single-beat accesses on a synchronous SRAM port.
// One transaction is in flight at a time. Simultaneous AW/AR requests are arbitrated round-robin.
module axi_mem_subordinate #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           ID_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           MEM_BYTES  = 65536,
  localparam int unsigned          NB         = DATA_WIDTH / 8,
  localparam int unsigned          MEM_AW     = $clog2(MEM_BYTES / NB)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [NB-1:0]         s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [NB-1:0]         mem_be_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned           NB_LOG     = $clog2(NB);
  localparam logic [1:0]            BURST_INCR = 2'b01;
  localparam logic [1:0]            RESP_OKAY  = 2'b00;
  localparam logic [1:0]            RESP_SLV   = 2'b10;
  localparam logic [ADDR_WIDTH:0]   WIN_BYTES  = (ADDR_WIDTH + 1)'(MEM_BYTES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic [1:0]              burst_q;
  logic                    cfg_err_q;
  logic                    err_q;
  logic                    wr_prio_q;
  logic                    beat_err_q;
  logic                    rd_first_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [ADDR_WIDTH-1:0]   off;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic                    beat_ok;
  logic                    last_beat;
  logic                    tie;
  logic                    aw_grant;
  logic                    ar_grant;
  logic                    aw_bad;
  logic                    ar_bad;

  // Beat decode: window check on the current beat address, round-robin grant on ties.
  always_comb begin
    off       = addr_q - BASE_ADDR;
    beat_ok   = !cfg_err_q && ({1'b0, off} < WIN_BYTES);
    last_beat = (cnt_q == len_q);
    addr_next = (burst_q == BURST_INCR) ? addr_q + ADDR_WIDTH'(NB) : addr_q;
    tie       = s_awvalid && s_arvalid;
    aw_grant  = s_awvalid && (!s_arvalid || wr_prio_q);
    ar_grant  = s_arvalid && !aw_grant;
    aw_bad    = s_awburst[1] || (s_awsize != 3'(NB_LOG));
    ar_bad    = s_arburst[1] || (s_arsize != 3'(NB_LOG));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (aw_grant)      state_d = WR_DATA;
        else if (ar_grant) state_d = RD_REQ;
      end
      WR_DATA: if (s_wvalid && last_beat) state_d = WR_RESP;
      WR_RESP: if (s_bready) state_d = IDLE;
      RD_REQ:  state_d = RD_DATA;
      RD_DATA: if (s_rready) state_d = last_beat ? IDLE : RD_REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_awready = 1'b0;
    s_arready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_rvalid  = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    case (state_q)
      IDLE: begin
        s_awready = aw_grant;
        s_arready = ar_grant;
      end
      WR_DATA: begin
        s_wready  = 1'b1;
        mem_req_o = s_wvalid && beat_ok;
        mem_we_o  = s_wvalid && beat_ok;
      end
      WR_RESP: s_bvalid  = 1'b1;
      RD_REQ:  mem_req_o = beat_ok;
      RD_DATA: s_rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Transaction context: captured at accept, advanced per beat.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      burst_q    <= '0;
      cfg_err_q  <= 1'b0;
      err_q      <= 1'b0;
      wr_prio_q  <= 1'b1;
      beat_err_q <= 1'b0;
      rd_first_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_grant) begin
            id_q      <= s_awid;
            addr_q    <= s_awaddr;
            len_q     <= s_awlen;
            burst_q   <= s_awburst;
            cnt_q     <= '0;
            cfg_err_q <= aw_bad;
            err_q     <= aw_bad;
            if (tie) wr_prio_q <= 1'b0;
          end else if (ar_grant) begin
            id_q      <= s_arid;
            addr_q    <= s_araddr;
            len_q     <= s_arlen;
            burst_q   <= s_arburst;
            cnt_q     <= '0;
            cfg_err_q <= ar_bad;
            err_q     <= ar_bad;
            if (tie) wr_prio_q <= 1'b1;
          end
        end
        WR_DATA: begin
          if (s_wvalid) begin
            if (!beat_ok || (s_wlast != last_beat)) err_q <= 1'b1;
            if (!last_beat) begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= addr_next;
            end
          end
        end
        RD_REQ: begin
          beat_err_q <= !beat_ok;
          rd_first_q <= 1'b1;
        end
        RD_DATA: begin
          rd_first_q <= 1'b0;
          if (rd_first_q) rdata_q <= beat_err_q ? '0 : mem_rdata_i;
          if (s_rready && !last_beat) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= addr_next;
          end
        end
        default: ;
      endcase
    end
  end

  // SRAM read data arrives in the first RD_DATA cycle; afterwards the held copy keeps R stable.
  always_comb begin
    s_bid       = id_q;
    s_bresp     = err_q ? RESP_SLV : RESP_OKAY;
    s_rid       = id_q;
    s_rresp     = (err_q || beat_err_q) ? RESP_SLV : RESP_OKAY;
    s_rlast     = last_beat;
    s_rdata     = rd_first_q ? (beat_err_q ? '0 : mem_rdata_i) : rdata_q;
    mem_addr_o  = MEM_AW'(off >> NB_LOG);
    mem_wdata_o = s_wdata;
    mem_be_o    = s_wstrb;
  end

endmodule
